// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates a fetch port and a data port onto one shared
//            backing-memory port. One transaction is outstanding at a time.
//            The data port has priority, but the fetch port is guaranteed a
//            grant after STARVE_LIMIT consecutive data grants. A transaction
//            that sees no mem_ack for TIMEOUT cycles is aborted: the owner
//            gets a valid pulse with zero read data, and err is set.
// Ports    : clk, rst_n                 clock, asynchronous active-low reset
//            if_req/if_addr             fetch request (level-held until valid)
//            if_rdata/if_valid/if_stall fetch response and pipeline hold
//            me_rd/me_wr/me_addr/me_wdata/me_wstrb  data request
//            me_rdata/me_valid/me_stall data response and pipeline hold
//            mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  memory request
//            mem_rdata/mem_ack          memory response
//            err                        sticky timeout flag
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  // data port
  input  logic        me_rd,
  input  logic        me_wr,
  input  logic [31:0] me_addr,
  input  logic [31:0] me_wdata,
  input  logic [3:0]  me_wstrb,
  output logic [31:0] me_rdata,
  output logic        me_valid,
  output logic        me_stall,
  // backing memory
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  // status
  output logic        err
);

  localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int c_TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
  localparam logic [c_TO_W-1:0]     c_TO_LAST    = c_TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    ME_BUSY = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [c_STARVE_W-1:0]   r_starve;
  logic [c_TO_W-1:0]       r_to_cnt;

  logic w_me_req;
  logic w_busy;
  logic w_turnaround;
  logic w_grant_if;
  logic w_grant_me;
  logic w_ack;
  logic w_abort;

  assign w_me_req     = me_rd | me_wr;
  assign w_busy       = (r_state != IDLE);
  // The cycle carrying a completion pulse is a turnaround cycle: the served
  // port's level-held request is stale, so nothing is granted and both ports
  // re-arbitrate together on the following cycle.
  assign w_turnaround = if_valid | me_valid;

  assign mem_req  = w_busy;
  assign if_stall = if_req & ~if_valid;
  assign me_stall = w_me_req & ~me_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Arbitration and next state
  always_comb begin
    w_grant_if   = 1'b0;
    w_grant_me   = 1'b0;
    w_ack        = w_busy & mem_ack;
    w_abort      = w_busy & ~mem_ack & (r_to_cnt == c_TO_LAST);
    w_next_state = r_state;

    if (!w_busy && !w_turnaround) begin
      if (w_me_req && if_req) begin
        // Data wins unless the fetch port has already waited out its quota.
        if (r_starve == c_STARVE_MAX) begin
          w_grant_if = 1'b1;
        end else begin
          w_grant_me = 1'b1;
        end
      end else begin
        w_grant_me = w_me_req;
        w_grant_if = if_req;
      end
    end

    if (w_grant_if) begin
      w_next_state = IF_BUSY;
    end else if (w_grant_me) begin
      w_next_state = ME_BUSY;
    end else if (w_ack || w_abort) begin
      w_next_state = IDLE;
    end
  end

  // Datapath, response and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      if_rdata  <= 32'd0;
      if_valid  <= 1'b0;
      me_rdata  <= 32'd0;
      me_valid  <= 1'b0;
      err       <= 1'b0;
      r_starve  <= '0;
      r_to_cnt  <= '0;
    end else begin
      if_valid <= 1'b0;
      me_valid <= 1'b0;

      if (w_grant_if) begin
        mem_addr  <= if_addr;
        mem_we    <= 1'b0;
        mem_wdata <= 32'd0;
        mem_wstrb <= 4'd0;
        r_to_cnt  <= '0;
        r_starve  <= '0;
      end else if (w_grant_me) begin
        // me_wr dominates when both read and write are asserted.
        mem_addr  <= me_addr;
        mem_we    <= me_wr;
        mem_wdata <= me_wdata;
        mem_wstrb <= me_wr ? me_wstrb : 4'd0;
        r_to_cnt  <= '0;
        if (if_req && (r_starve != c_STARVE_MAX)) begin
          r_starve <= r_starve + 1'b1;
        end
      end else if (w_ack) begin
        if (r_state == IF_BUSY) begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          me_valid <= 1'b1;
          if (!mem_we) begin
            me_rdata <= mem_rdata;
          end
        end
      end else if (w_abort) begin
        err <= 1'b1;
        if (r_state == IF_BUSY) begin
          if_valid <= 1'b1;
          if_rdata <= 32'd0;
        end else begin
          me_valid <= 1'b1;
          me_rdata <= 32'd0;
        end
      end else if (w_busy) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data-port grants while fetch port waits.
REQ-002 Parameter TIMEOUT, default 64: cycles mem_req may stay high without mem_ack before abort.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-low.
REQ-005 if_req  in  1  fetch request, level-held until if_valid.
REQ-006 if_addr  in  32  fetch address, stable while if_req high.
REQ-007 me_rd / me_wr  in  1 each  data read / write request, level-held until me_valid.
REQ-008 me_addr, me_wdata  in  32 each  data address / write data; me_wstrb  in  4  byte enables.
REQ-009 if_rdata, me_rdata  out  32 each  registered read data.
REQ-010 if_valid, me_valid  out  1 each  one-cycle completion pulse.
REQ-011 if_stall, me_stall  out  1 each  pipeline hold: port requesting and not valid this cycle.
REQ-012 mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  32; mem_wstrb  out  4: shared backing-memory port.
REQ-013 mem_rdata  in  32; mem_ack  in  1  memory completion, sampled at rising edge.
REQ-014 err  out  1  sticky timeout flag.

Function
REQ-015 FSM states IDLE, IF_BUSY, ME_BUSY, one transaction outstanding at a time.
REQ-016 Data request = me_rd | me_wr; both high -> write, me_rd ignored.
REQ-017 IDLE, data request only -> ME_BUSY; fetch only -> IF_BUSY; neither -> IDLE.
REQ-018 IDLE, both pending -> ME_BUSY, unless starve counter == STARVE_LIMIT -> IF_BUSY.
REQ-019 Starve counter: +1 on each ME grant while if_req pending; cleared on any IF grant; saturates at STARVE_LIMIT.
REQ-020 Served port is masked in IDLE during its valid cycle; req still high next cycle = new transaction.
REQ-021 BUSY: mem_req=1, mem_addr/mem_we/mem_wdata/mem_wstrb registered at grant, held constant until exit.
REQ-022 IF_BUSY: mem_we=0, mem_wstrb=0.
REQ-023 Edge with mem_ack=1 in BUSY: -> IDLE; next cycle mem_req=0, owner valid=1 for one cycle.
REQ-024 Ack on read: owner rdata <= mem_rdata; ack on write: me_rdata unchanged.
REQ-025 Non-owner rdata and valid unaffected; mem_ack in IDLE ignored.
REQ-026 Minimum latency: req high cycle 0, mem_req cycle 1, ack cycle 1, valid cycle 2.
REQ-027 if_stall = if_req & ~if_valid; me_stall = (me_rd|me_wr) & ~me_valid; combinational.
REQ-028 Timeout counter cleared at grant, +1 each BUSY cycle without ack.
REQ-029 Counter == TIMEOUT-1 with no ack at edge: abort to IDLE, owner valid pulse, owner rdata <= 0, err <= 1.
REQ-030 Ack on same edge as timeout: ack wins, no err.
REQ-031 err cleared only by reset.

Reset
REQ-032 rst low: state IDLE, all outputs 0, starve and timeout counters 0, err 0, immediately without clock.
REQ-033 Reset mid-transaction drops it, no valid pulse; after release re-arbitrate from IDLE.

Verification
REQ-034 Single fetch if_addr=0x10, ack cycle 1, mem_rdata=0x00000013 -> mem_req cycle 1, if_valid cycle 2, if_rdata=0x00000013.
REQ-035 Data write me_addr=0x8, wdata=0xDEADBEEF, wstrb=0xF, ack after 3 cycles -> mem_we=1, fields held 3 cycles, me_valid once, me_rdata unchanged.
REQ-036 Both req held, ack every cycle -> 4 ME grants, then 1 IF grant, pattern repeats; no duplicate grant per valid.
REQ-037 Fetch, mem_ack never -> mem_req high 64 cycles, if_valid pulse, if_rdata=0, err=1 until reset.
REQ-038 rst low during ME_BUSY -> mem_req=0 at once, no me_valid; release with me_rd high -> new grant from IDLE.
